// File: rtl/network_interface_unit_if.sv
// Core/router-facing signal bundle of the network interface unit.
// master = pipeline + router side, slave = the unit itself.
interface network_interface_unit_if #(
   parameter int DEST_WIDTH = 8
);
   logic                  net_write;
   logic                  net_read;
   logic [2:0]            net_funct3;
   logic [31:0]           address;
   logic [31:0]           write_data;
   logic [31:0]           read_data;
   logic                  busy;
   logic [DEST_WIDTH+31:0] tx_packet;
   logic                  tx_valid;
   logic                  tx_ready;
   logic [31:0]           rx_data;
   logic                  rx_valid;
   logic                  rx_ready;

   modport master (
      output net_write, net_read, net_funct3, address, write_data,
      output tx_ready, rx_data, rx_valid,
      input  read_data, busy, tx_packet, tx_valid, rx_ready
   );

   modport slave (
      input  net_write, net_read, net_funct3, address, write_data,
      input  tx_ready, rx_data, rx_valid,
      output read_data, busy, tx_packet, tx_valid, rx_ready
   );
endinterface

// File: rtl/network_interface_unit.sv
// SWNET/LWNET network interface: TX and RX FIFOs between pipeline and router.
// Optional status read (funct3=3'b111) is enabled by defining NIU_STATUS_EN.
module niu_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     full
);
   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0]   FULL_COUNT = (PW+1)'(DEPTH);
   localparam logic [PW:0]   COUNT_ONE  = (PW+1)'(1);
   localparam logic [PW-1:0] PTR_ONE    = (PW)'(1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr_reg;
   logic [PW-1:0]    rd_ptr_reg;
   logic [PW:0]      count_reg;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count_reg == '0);
   assign full    = (count_reg == FULL_COUNT);
   assign do_pop  = pop & ~empty;
   // A pop frees the slot on the same edge, so push-on-full is legal with a pop.
   assign do_push = push & (~full | do_pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + COUNT_ONE;
            2'b01:   count_reg <= count_reg - COUNT_ONE;
            default: count_reg <= count_reg;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_reg] <= wdata;
   end

   // Stale storage must never leak out of an empty FIFO (e.g. after reset).
   assign head  = empty ? '0 : mem[rd_ptr_reg];
   assign count = count_reg;
endmodule

module network_interface_unit #(
   parameter int FIFO_DEPTH = 4,
   parameter int DEST_WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   network_interface_unit_if.slave  bus
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic [DEST_WIDTH+31:0] tx_head;
   logic [CW-1:0]          tx_count;
   logic                   tx_empty;
   logic                   tx_full;
   logic                   tx_push;
   logic                   tx_pop;

   logic [31:0]            rx_head;
   logic [CW-1:0]          rx_count;
   logic                   rx_empty;
   logic                   rx_full;
   logic                   rx_push;
   logic                   rx_pop;

   logic                   status_rd;
   logic [31:0]            status_word;
   logic [31:0]            read_data_next;
   logic                   busy_next;

   niu_fifo #(.WIDTH(DEST_WIDTH + 32), .DEPTH(FIFO_DEPTH)) tx_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (tx_push),
      .pop   (tx_pop),
      .wdata ({bus.address[DEST_WIDTH-1:0], bus.write_data}),
      .head  (tx_head),
      .count (tx_count),
      .empty (tx_empty),
      .full  (tx_full)
   );

   niu_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) rx_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (rx_push),
      .pop   (rx_pop),
      .wdata (bus.rx_data),
      .head  (rx_head),
      .count (rx_count),
      .empty (rx_empty),
      .full  (rx_full)
   );

`ifdef NIU_STATUS_EN
   assign status_rd = bus.net_read & ~bus.net_write & (bus.net_funct3 == 3'b111);
`else
   assign status_rd = 1'b0;
`endif
   assign status_word = {16'h0000, 8'(rx_count), 8'(tx_count)};

   // Only a non-full TX FIFO takes a write; a stalled SWNET retries every cycle.
   assign tx_push = bus.net_write & ~tx_full;
   assign tx_pop  = ~tx_empty & bus.tx_ready;
   assign rx_push = bus.rx_valid & ~rx_full;

   // Write wins over read; the read path is only considered when no SWNET is present.
   always_comb begin
      read_data_next = '0;
      busy_next      = 1'b0;
      rx_pop         = 1'b0;
      if (!rst) begin
         if (bus.net_write) begin
            busy_next = tx_full;
         end else if (bus.net_read) begin
            if (status_rd) begin
               read_data_next = status_word;
            end else if (rx_empty) begin
               busy_next = 1'b1;
            end else begin
               read_data_next = rx_head;
               rx_pop         = 1'b1;
            end
         end
      end
   end

   assign bus.read_data = read_data_next;
   assign bus.busy      = busy_next;
   assign bus.tx_valid  = ~tx_empty;
   assign bus.tx_packet = tx_head;
   assign bus.rx_ready  = ~rx_full;
endmodule
